sng_stream_sched: RTL and testbench
===================================

Name: sng_stream_sched

Overview:
- Round-robin scheduler sharing one SNG instance (QUOTA -> WEYL -> PHASE_3b, internal 3-bit phase counter k) among NUM_REQ weight requesters.
- Grants one requester per burst and forwards its weights to the SNG.
- Drives the SNG w_valid/r_ready/wlast so the internal k sequences correctly.
- Registers each resulting bitstream onto a valid/ready output tagged with requester id and phase.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- QUANT, 8, weight width
- BITSTREAM, 64, SNG bitstream length
- PHASES, 8, SNG phase count (k width = 3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester weight valid
- req_data  in  NUM_REQ*QUANT  packed weights, requester i at [i*QUANT +: QUANT]
- req_last  in  NUM_REQ  last weight of requester burst
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- sng_w_data  out  QUANT  to SNG w_data
- sng_w_valid  out  1  to SNG w_valid
- sng_r_ready  out  1  to SNG r_ready
- sng_wlast  out  1  to SNG wlast
- sng_bitstream  in  BITSTREAM  from SNG r_bitstream (combinational in current k)
- out_valid  out  1  bitstream valid
- out_ready  in  1  downstream accept
- out_bitstream  out  BITSTREAM  registered bitstream
- out_id  out  $clog2(NUM_REQ)  source requester
- out_phase  out  3  k used for this beat
- out_last  out  1  beat was requester's last

Behaviour:
- Interface decision: one clock, clk; reset rst, synchronous and active-high. The SNG rst_n is driven as ~rst by the integrator.
- FSM states: FLUSH, IDLE, STREAM.
- Reset:
  - state=FLUSH, rr_ptr=NUM_REQ-1, k_mirror=0, grant=0.
  - out_valid=0; out_bitstream, out_id, out_phase, out_last = 0.
  - All req_ready and sng_* outputs = 0.
- FLUSH:
  - Lasts exactly one cycle; sng_wlast=1, sng_w_valid=0, sng_r_ready=0.
  - Forces SNG k=0 even if the SNG reset was missed. Then -> IDLE.
- IDLE:
  - If any req_valid, grant = first set index searching rr_ptr+1, rr_ptr+2, ... (mod NUM_REQ) -> STREAM next cycle.
  - No forwarding in the grant cycle.
- STREAM:
  - g = granted index; slot_free = !out_valid | out_ready.
  - sng_w_data = req_data[g]; sng_w_valid = req_valid[g]; sng_r_ready = slot_free.
  - req_ready[g] = slot_free; all other req_ready = 0.
  - fire = req_valid[g] & slot_free.
  - On fire: out_bitstream <= sng_bitstream; out_id <= g; out_phase <= k_mirror; out_last <= req_last[g]; out_valid <= 1.
  - On fire, k_mirror increments, wrapping 7->0.
  - sng_wlast = fire & req_last[g]; never asserted without fire, because SNG wlast has priority over increment.
  - fire & req_last[g]: k_mirror <= 0, rr_ptr <= g, -> IDLE.
- Grant is held across requester bubbles (req_valid[g]=0). No preemption, no timeout.
- Output register:
  - out_ready & out_valid without fire -> out_valid <= 0.
  - Simultaneous accept and fire -> new beat loads, out_valid stays 1 (full throughput, 1 beat/cycle).
- Latency: fire at cycle t -> out_valid with that beat at t+1.
- Bursts longer than PHASES wrap k naturally. out_phase reflects the wrapped value.
- Idle gap: one IDLE cycle between bursts. Max throughput is (L)/(L+1) for bursts of length L.
- Reset mid-burst: returns to FLUSH and drops the in-flight output beat. Requester must restart its burst.
- Invariant: k_mirror equals the SNG internal k at all times outside FLUSH.

Test Plan:
- Reset, then idle: FLUSH cycle shows sng_wlast=1 only. Afterwards all outputs 0; out_valid=0 with no requests.
- Req 1 sends 3 weights (0x10, 0x80, 0xFF, last on 3rd), out_ready=1:
  - 3 beats, out_id=1, out_phase=0,1,2, out_last=0,0,1.
  - out_bitstream equals the golden SNG model.
  - sng_wlast pulses only with the 3rd fire.
- Reqs 0, 2, 3 all valid with 1-beat bursts: grant order 0, 2, 3, then 0 again. rr_ptr is updated after each last beat.
- Req 0 sends a 10-beat burst: out_phase = 0..7, 0, 1; k returns to 0 after last.
- out_ready held low 4 cycles mid-burst:
  - req_ready and sng_r_ready = 0.
  - out_bitstream and out_phase stable; no k advance.
  - Resumes with the next phase and no beat lost.
- rst asserted after 2 beats of a 5-beat burst: FLUSH, out_valid=0. Next burst starts at out_phase=0.

Source files
------------

// File: rtl/sng_stream_sched.sv
// Purpose: round-robin scheduler that time-shares one SNG among NUM_REQ weight requesters.
// Latency: a weight accepted (fire) at cycle t appears as a registered bitstream beat at t+1.
// Backpressure: out_ready low with a full output slot drops req_ready and sng_r_ready, freezing SNG phase k.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_valid/req_data/req_last/req_ready   per-requester weight streams (req_ready one-hot or zero)
//   sng_w_data/sng_w_valid/sng_r_ready/sng_wlast   drive the shared SNG
//   sng_bitstream              SNG bitstream, combinational in the SNG's current k
//   out_valid/out_ready/out_bitstream/out_id/out_phase/out_last   registered output beat
module sng_stream_sched #(
    parameter int NUM_REQ   = 4,
    parameter int QUANT     = 8,
    parameter int BITSTREAM = 64,
    parameter int PHASES    = 8,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*QUANT-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_last,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [QUANT-1:0]         sng_w_data,
    output logic                     sng_w_valid,
    output logic                     sng_r_ready,
    output logic                     sng_wlast,
    input  logic [BITSTREAM-1:0]     sng_bitstream,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITSTREAM-1:0]     out_bitstream,
    output logic [ID_W-1:0]          out_id,
    output logic [2:0]               out_phase,
    output logic                     out_last
);

    typedef enum logic [1:0] {
        FLUSH  = 2'd0,
        IDLE   = 2'd1,
        STREAM = 2'd2
    } state_t;

    typedef struct packed {
        logic [BITSTREAM-1:0] bits;
        logic [ID_W-1:0]      id;
        logic [2:0]           phase;
        logic                 last;
    } beat_t;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] pick;
    logic            pick_vld;
    logic [2:0]      k_mirror;
    logic [2:0]      k_inc;
    beat_t           out_q;
    logic            out_vld_q;

    logic             active;
    logic             streaming;
    logic             g_vld;
    logic             g_last;
    logic [QUANT-1:0] g_dat;
    logic             slot_free;
    logic             fire;

    // Outputs are forced to zero while rst is held so the SNG sees no
    // stray wlast/handshake; FLUSH then lasts exactly one cycle after release.
    assign active    = !rst;
    assign streaming = active && (state == STREAM);
    assign g_vld     = req_valid[grant];
    assign g_last    = req_last[grant];
    assign g_dat     = req_data[int'(grant)*QUANT +: QUANT];
    assign slot_free = !out_vld_q || out_ready;
    assign fire      = streaming && g_vld && slot_free;
    assign k_inc     = (k_mirror == 3'(PHASES-1)) ? 3'd0 : k_mirror + 3'd1;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!pick_vld && req_valid[ID_W'((int'(rr_ptr) + i) % NUM_REQ)]) begin
                pick_vld = 1'b1;
                pick     = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Next state and SNG/requester handshake outputs.
    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        sng_w_data  = '0;
        sng_w_valid = 1'b0;
        sng_r_ready = 1'b0;
        sng_wlast   = 1'b0;
        case (state)
            FLUSH: begin
                // wlast without a handshake parks the SNG at k=0 whatever its reset history.
                sng_wlast = active;
                state_nxt = IDLE;
            end
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (streaming) begin
                    sng_w_data       = g_dat;
                    sng_w_valid      = g_vld;
                    sng_r_ready      = slot_free;
                    req_ready[grant] = slot_free;
                end
                // SNG gives wlast priority over increment, so it only rides on the final fire.
                sng_wlast = fire && g_last;
                if (fire && g_last) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = FLUSH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FLUSH;
            rr_ptr    <= ID_W'(NUM_REQ-1);
            k_mirror  <= 3'd0;
            grant     <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                k_mirror <= 3'd0;
            end
            if ((state == IDLE) && pick_vld) begin
                grant <= pick;
            end
            if (fire) begin
                out_q.bits  <= sng_bitstream;
                out_q.id    <= grant;
                out_q.phase <= k_mirror;
                out_q.last  <= g_last;
                out_vld_q   <= 1'b1;
                if (g_last) begin
                    k_mirror <= 3'd0;
                    rr_ptr   <= grant;
                end else begin
                    k_mirror <= k_inc;
                end
            end else if (out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_vld_q;
    assign out_bitstream = out_q.bits;
    assign out_id        = out_q.id;
    assign out_phase     = out_q.phase;
    assign out_last      = out_q.last;

endmodule

// File: tb/tb_sng_stream_sched.sv
// Testbench for sng_stream_sched: behavioural SNG with its own k register,
// per-requester burst drivers, and an in-order scoreboard of expected beats.
module tb_sng_stream_sched;

    localparam int NUM_REQ   = 4;
    localparam int QUANT     = 8;
    localparam int BITSTREAM = 64;
    localparam int PHASES    = 8;
    localparam int ID_W      = 2;

    typedef struct packed {
        logic [QUANT-1:0] w;
        logic             last;
    } drv_beat_t;

    typedef struct {
        logic [ID_W-1:0]      id;
        logic [2:0]           ph;
        logic [BITSTREAM-1:0] bs;
        logic                 last;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*QUANT-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic [QUANT-1:0]         sng_w_data;
    logic                     sng_w_valid;
    logic                     sng_r_ready;
    logic                     sng_wlast;
    logic [BITSTREAM-1:0]     sng_bitstream;
    logic                     out_valid;
    logic                     out_ready;
    logic [BITSTREAM-1:0]     out_bitstream;
    logic [ID_W-1:0]          out_id;
    logic [2:0]               out_phase;
    logic                     out_last;

    sng_stream_sched #(
        .NUM_REQ(NUM_REQ), .QUANT(QUANT), .BITSTREAM(BITSTREAM), .PHASES(PHASES)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .sng_w_data(sng_w_data), .sng_w_valid(sng_w_valid), .sng_r_ready(sng_r_ready),
        .sng_wlast(sng_wlast), .sng_bitstream(sng_bitstream),
        .out_valid(out_valid), .out_ready(out_ready), .out_bitstream(out_bitstream),
        .out_id(out_id), .out_phase(out_phase), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Golden SNG: quota from weight, Weyl walk over the bit positions, phase offset from k.
    function automatic logic [BITSTREAM-1:0] sng_golden(input logic [QUANT-1:0] w, input logic [2:0] k);
        logic [BITSTREAM-1:0] r;
        int quota;
        quota = int'(w) >> 2;
        for (int j = 0; j < BITSTREAM; j++) begin
            r[j] = (((j * 37) + (int'(k) * 8)) % 64) < quota;
        end
        return r;
    endfunction

    // SNG model deliberately ignores rst and starts at k=5: only the scheduler's flush can realign it.
    logic [2:0] sng_k = 3'd5;
    always @(posedge clk) begin
        if (sng_wlast) sng_k <= 3'd0;
        else if (sng_w_valid && sng_r_ready) sng_k <= sng_k + 3'd1;
    end
    assign sng_bitstream = sng_golden(sng_w_data, sng_k);

    drv_beat_t drvq[NUM_REQ][$];
    exp_t      sbq[$];
    int        id_log[$];
    int        beat_cnt[NUM_REQ];
    int        hs_cnt[NUM_REQ];
    int        n_vec = 0;
    int        n_err = 0;
    int        spurious_wlast = 0;
    bit        rand_ordy = 1'b0;
    bit        bubble_en = 1'b0;
    bit        stall_prev = 1'b0;
    logic [BITSTREAM-1:0] held_bs;
    logic [2:0]           held_ph;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (drvq[i].size() > 0) begin
                req_data[i*QUANT +: QUANT] = drvq[i][0].w;
                req_last[i]  = drvq[i][0].last;
                req_valid[i] = bubble_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic push_burst(input int id, input int len, input int seed);
        drv_beat_t b;
        for (int n = 0; n < len; n++) begin
            b.w    = QUANT'((seed + n * 53) % 256);
            b.last = (n == len - 1);
            drvq[id].push_back(b);
        end
    endtask

    // One clock: monitor at negedge, then drive just after the posedge.
    task automatic step();
        logic [NUM_REQ-1:0] hs;
        exp_t e;
        @(negedge clk);
        hs = req_valid & req_ready;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check_val("unexpected_beat", 1, 0);
            end else begin
                e = sbq.pop_front();
                check_val("out_id", out_id, e.id);
                check_val("out_phase", out_phase, e.ph);
                check_val("out_last", out_last, e.last);
                check_val("out_bitstream", out_bitstream, e.bs);
                id_log.push_back(int'(out_id));
            end
        end
        if (out_valid && !out_ready) begin
            check_val("stall_ready", {req_ready, sng_r_ready}, 0);
            if (stall_prev) begin
                check_val("stall_bs_stable", out_bitstream, held_bs);
                check_val("stall_phase_stable", out_phase, held_ph);
            end
            held_bs    = out_bitstream;
            held_ph    = out_phase;
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (hs != '0) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    e.id   = ID_W'(i);
                    e.ph   = 3'(beat_cnt[i] % PHASES);
                    e.bs   = sng_golden(drvq[i][0].w, e.ph);
                    e.last = drvq[i][0].last;
                    sbq.push_back(e);
                    check_val("wlast_with_fire", sng_wlast, drvq[i][0].last);
                    beat_cnt[i] = drvq[i][0].last ? 0 : beat_cnt[i] + 1;
                    hs_cnt[i]++;
                end
            end
        end else if (sng_wlast) begin
            spurious_wlast++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs[i]) void'(drvq[i].pop_front());
        end
        drive_reqs();
        if (rand_ordy) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic run_until_done(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            done = (sbq.size() == 0) && !out_valid;
            for (int i = 0; i < NUM_REQ; i++) done = done && (drvq[i].size() == 0);
            if (!done) step();
        end
        check_val("drain_in_budget", done, 1);
    endtask

    task automatic reset_and_flush();
        rst        = 1'b1;
        req_valid  = '0;
        stall_prev = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_bitstream", out_bitstream, 0);
        check_val("rst_out_id", out_id, 0);
        check_val("rst_out_phase", out_phase, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_req_ready", req_ready, 0);
        check_val("rst_sng_w_valid", sng_w_valid, 0);
        check_val("rst_sng_r_ready", sng_r_ready, 0);
        check_val("rst_sng_wlast", sng_wlast, 0);
        check_val("rst_sng_w_data", sng_w_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("flush_wlast", sng_wlast, 1);
        check_val("flush_w_valid", sng_w_valid, 0);
        check_val("flush_r_ready", sng_r_ready, 0);
        check_val("flush_req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_val("post_flush_wlast", sng_wlast, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            beat_cnt[i] = 0;
            hs_cnt[i]   = 0;
        end

        // Reset, flush, then idle with no requests.
        reset_and_flush();
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("idle_out_valid", out_valid, 0);
        end

        // Round robin from rr_ptr=3: requesters 0,2,3 with single-beat bursts, 0 twice.
        id_log.delete();
        push_burst(0, 1, 8'h11);
        push_burst(0, 1, 8'h22);
        push_burst(2, 1, 8'h33);
        push_burst(3, 1, 8'h44);
        drive_reqs();
        run_until_done(100);
        check_val("rr_count", id_log.size(), 4);
        if (id_log.size() == 4) begin
            check_val("rr_grant0", id_log[0], 0);
            check_val("rr_grant1", id_log[1], 2);
            check_val("rr_grant2", id_log[2], 3);
            check_val("rr_grant3", id_log[3], 0);
        end

        // Requester 1: three weights, last on the third.
        id_log.delete();
        drvq[1].push_back('{w: 8'h10, last: 1'b0});
        drvq[1].push_back('{w: 8'h80, last: 1'b0});
        drvq[1].push_back('{w: 8'hFF, last: 1'b1});
        drive_reqs();
        run_until_done(100);
        check_val("req1_beats", id_log.size(), 3);

        // Ten-beat burst wraps k past 7, with requester bubbles; then a 1-beat burst at phase 0.
        bubble_en = 1'b1;
        push_burst(0, 10, 8'h05);
        push_burst(0, 1, 8'hC4);
        push_burst(2, 2, 8'h61);
        drive_reqs();
        run_until_done(400);
        bubble_en = 1'b0;

        // Backpressure: out_ready low for 4 cycles after three beats of a 6-beat burst.
        hs_cnt[3] = 0;
        push_burst(3, 6, 8'h27);
        drive_reqs();
        for (int c = 0; c < 50 && hs_cnt[3] < 3; c++) step();
        check_val("stall_setup_hs", hs_cnt[3], 3);
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        run_until_done(100);

        // Reset after two beats of a 5-beat burst; next burst restarts at phase 0.
        hs_cnt[2] = 0;
        push_burst(2, 5, 8'h9A);
        drive_reqs();
        for (int c = 0; c < 50 && hs_cnt[2] < 2; c++) step();
        check_val("rst_setup_hs", hs_cnt[2], 2);
        drvq[2].delete();
        beat_cnt[2] = 0;
        reset_and_flush();
        check_val("dropped_beat", sbq.size(), 1);
        sbq.delete();
        push_burst(2, 3, 8'h3C);
        drive_reqs();
        run_until_done(100);

        // Mixed random traffic with random downstream backpressure.
        rand_ordy = 1'b1;
        for (int b = 0; b < 8; b++) begin
            push_burst($urandom_range(0, NUM_REQ-1), $urandom_range(1, 5), $urandom_range(4, 255));
        end
        drive_reqs();
        run_until_done(600);
        rand_ordy = 1'b0;
        out_ready = 1'b1;

        check_val("spurious_wlast", spurious_wlast, 0);
        check_val("scoreboard_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
